// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-RAM write port of the boot loader.
// The loader sits on the slave side; host link and RAM model use the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, XOR-checked byte stream -> LE 32-bit IMEM words; holds CPU until verified.
// One byte/cycle; RAM write registered 1 cycle after the 4th byte; byte_ready is a pure state decode.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam logic [16:0] DEPTH_V = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    len_lo;
  logic [15:0]   n_len;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] wc_inc;
  logic [1:0]    byte_idx;
  logic [7:0]    csum;
  logic [23:0]   word_asm;

  logic          xfer;
  logic [15:0]   len_val;
  logic          len_bad;
  logic          last_word;
  logic          word_done;

  assign bus.byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                          (state == S_DATA)   || (state == S_CHECK);
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign len_val   = {bus.byte_data, len_lo};
  assign len_bad   = (len_val == 16'd0) || ({1'b0, len_val} > DEPTH_V);
  assign wc_inc    = word_cnt + 1'b1;
  assign last_word = (16'(wc_inc) == n_len);
  assign word_done = xfer && (state == S_DATA) && (byte_idx == 2'd3);

  assign cpu_hold = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer)  state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer)  state_nxt = len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (word_done && last_word) state_nxt = S_CHECK;
      S_CHECK:  if (xfer)  state_nxt = (bus.byte_data == csum) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:  if (start) state_nxt = S_LEN_LO;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bytes shift in from the top so that after three bytes word_asm = {b2, b1, b0}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo        <= '0;
      n_len         <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      csum          <= '0;
      word_asm      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= word_done;
      if (xfer) begin
        unique case (state)
          S_LEN_LO: len_lo <= bus.byte_data;
          S_LEN_HI: begin
            n_len    <= len_val;
            word_cnt <= '0;
            byte_idx <= '0;
            csum     <= '0;
            word_asm <= '0;
          end
          S_DATA: begin
            word_asm <= {bus.byte_data, word_asm[23:8]};
            csum     <= csum ^ bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.mem_addr  <= word_cnt[ADDR_W-1:0];
              bus.mem_wdata <= {bus.byte_data, word_asm};
              word_cnt      <= wc_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-image loads plus hand sequences for
// reset, full-depth load, flow-control gaps with a stray start, and reset mid-load.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, done, error;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  ck;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Presents a byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    while (bus.byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) begin
      failures++;
      checks++;
      $display("FAIL send_timeout actual=byte_ready_low expected=byte_ready_high");
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_nominal();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678); send_word(32'hDEADBEEF);
    send_byte(8'h2A);
  endtask

  task automatic check_nominal_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    chk({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0);
    chk({tag, "_data0"}, wr_data[0], 32'h12345678);
    chk({tag, "_addr1"}, 32'(wr_addr[1]), 32'h1);
    chk({tag, "_data1"}, wr_data[1], 32'hDEADBEEF);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  xs;

    vecs[0] = '{"nominal",     8'h02, 8'h00, 2, 32'h12345678, 32'hDEADBEEF, 8'h2A, 1'b1, 1'b0};
    vecs[1] = '{"bad_csum",    8'h02, 8'h00, 2, 32'h12345678, 32'hDEADBEEF, 8'h2B, 1'b0, 1'b1};
    vecs[2] = '{"recover",     8'h02, 8'h00, 2, 32'h12345678, 32'hDEADBEEF, 8'h2A, 1'b1, 1'b0};
    vecs[3] = '{"len_zero",    8'h00, 8'h00, 0, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1};
    vecs[4] = '{"len_257",     8'h01, 8'h01, 0, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1};
    vecs[5] = '{"one_word_z",  8'h01, 8'h00, 1, 32'hA5A50F0F, 32'h0,        8'h00, 1'b1, 1'b0};
    vecs[6] = '{"one_word",    8'h01, 8'h00, 1, 32'h01020304, 32'h0,        8'h04, 1'b1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

    // Stream without start: nothing accepted, nothing written.
    clear_log();
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.byte_data = 8'(k);
      @(negedge clk);
      chk("nostart_ready", 32'(bus.byte_ready), 32'd0);
    end
    bus.byte_valid = 1'b0;
    chk("nostart_writes", 32'(wr_addr.size()), 32'd0);

    for (int i = 0; i < 7; i++) begin
      clear_log();
      pulse_start();
      chk({vecs[i].name, "_ready_after_start"}, 32'(bus.byte_ready), 32'd1);
      send_byte(vecs[i].lo);
      send_byte(vecs[i].hi);
      for (int k = 0; k < vecs[i].nw; k++) send_word(k == 0 ? vecs[i].w0 : vecs[i].w1);
      if (vecs[i].nw > 0) send_byte(vecs[i].ck);
      chk({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].exp_done));
      chk({vecs[i].name, "_error"}, 32'(error), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_cpu_hold"}, 32'(cpu_hold), 32'(!vecs[i].exp_done));
      chk({vecs[i].name, "_ready_term"}, 32'(bus.byte_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk({vecs[i].name, "_nwrites"}, 32'(wr_addr.size()), 32'(vecs[i].nw));
      for (int k = 0; k < vecs[i].nw; k++) begin
        chk({vecs[i].name, "_addr"}, 32'(wr_addr[k]), 32'(k));
        chk({vecs[i].name, "_data"}, wr_data[k], k == 0 ? vecs[i].w0 : vecs[i].w1);
      end
      if (vecs[i].nw == 2)
        chk({vecs[i].name, "_we_spacing"}, 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
    end

    // Full-depth image: N = 256 fills addresses 0..255.
    clear_log();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    xs = 8'h00;
    for (int k = 0; k < 256; k++) begin
      w = {8'h3C, ~8'(k), 8'(k) ^ 8'hA5, 8'(k)};
      xs = xs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w);
    end
    chk("full_not_done_before_ck", 32'(done), 32'd0);
    send_byte(xs);
    chk("full_done", 32'(done), 32'd1);
    chk("full_cpu_hold", 32'(cpu_hold), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("full_nwrites", 32'(wr_addr.size()), 32'd256);
    for (int k = 0; k < 256; k++) begin
      w = {8'h3C, ~8'(k), 8'(k) ^ 8'hA5, 8'(k)};
      chk("full_addr", 32'(wr_addr[k]), 32'(k));
      chk("full_data", wr_data[k], w);
    end
    chk("full_last_addr", 32'(wr_addr[255]), 32'hFF);

    // Gapped stream with a stray start during DATA.
    begin
      logic [7:0] stream[11];
      stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      clear_log();
      pulse_start();
      for (int k = 0; k < 11; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        if (k == 5) begin
          pulse_start();
          chk("flow_start_ignored_ready", 32'(bus.byte_ready), 32'd1);
        end
        send_byte(stream[k]);
      end
      chk("flow_done", 32'(done), 32'd1);
      chk("flow_error", 32'(error), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_nominal_writes("flow");
    end

    // Reset after six data bytes: the partial second word must never be written.
    clear_log();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678);
    send_byte(8'hEF); send_byte(8'hBE);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    chk("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);
    clear_log();
    pulse_start();
    send_nominal();
    chk("midrst_reload_done", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_nominal_writes("midrst_reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
